// File: rtl/psum_reader_pkg.sv
// Shared layer-wide definitions for the partial-sum readout path.
// Also provides the index-width helper used by the reader.
package psum_reader_pkg;

    localparam int RELU_NODES            = 2;
    localparam int LAYER_1_OUT_BIT_WIDTH = 8;

    // A single-node layer still carries a 1-bit index.
    function automatic int idx_width(input int nodes);
        return (nodes > 1) ? $clog2(nodes) : 1;
    endfunction

endpackage

// File: rtl/psum_reader_relu_unit.sv
// Combinational ReLU: negative two's-complement sums clamp to zero,
// non-negative sums pass through unchanged.
module relu_unit #(
    parameter int SUM_W = 8
) (
    input  logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] relu
);

    assign relu = sum[SUM_W-1] ? '0 : sum;

endmodule

// File: rtl/psum_reader.sv
// Captures a layer's partial-sum vector on load and streams the ReLU'd
// node values out one per valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for load
//   DRAIN | snapshot held, presenting node[idx] until all nodes transfer
//   DONE  | one-cycle completion pulse; a load here is captured as in IDLE
module psum_reader
    import psum_reader_pkg::*;
#(
    parameter int NODES = RELU_NODES,
    parameter int SUM_W = LAYER_1_OUT_BIT_WIDTH
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [NODES*SUM_W-1:0]      sum_in,
    input  logic                        load,
    output logic                        acc_clr,
    output logic [SUM_W-1:0]            node_data,
    output logic [idx_width(NODES)-1:0] node_idx,
    output logic                        node_valid,
    input  logic                        node_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int IDX_W = idx_width(NODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [NODES*SUM_W-1:0] snap;
    logic [IDX_W-1:0]       idx;
    logic [SUM_W-1:0]       sel_sum;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            snap    <= '0;
            idx     <= '0;
            acc_clr <= 1'b0;
            overrun <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        snap    <= sum_in;
                        idx     <= '0;
                        acc_clr <= 1'b1;
                        state   <= DRAIN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                DRAIN: begin
                    // A load here would tear the snapshot; flag it and drop it.
                    if (load)
                        overrun <= 1'b1;
                    if (node_ready) begin
                        if (idx == LAST_IDX)
                            state <= DONE;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel_sum    = snap[idx*SUM_W +: SUM_W];
    assign node_idx   = idx;
    assign node_valid = (state == DRAIN);
    assign busy       = (state == DRAIN);
    assign done       = (state == DONE);

    relu_unit #(
        .SUM_W (SUM_W)
    ) u_relu (
        .sum  (sel_sum),
        .relu (node_data)
    );

endmodule
